// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester round-robin data memory arbiter
// Partial-store read-modify-write is compiled in with `define DMEM_ARB_RMW_EN.
module dmem_arbiter #(
    parameter  int DATA_WIDTH_POW = 6,
    parameter  int ADDR_WIDTH_POW = 6,
    localparam int DW             = 1 << DATA_WIDTH_POW,
    localparam int AW             = 1 << ADDR_WIDTH_POW,
    localparam int BE             = DW / 8
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic [1:0]        rq_valid,
    output logic [1:0]        rq_ready,
    input  logic [1:0]        rq_write,
    input  logic [2*AW-1:0]   rq_addr,
    input  logic [2*DW-1:0]   rq_wdata,
    input  logic [2*BE-1:0]   rq_be,
    output logic [1:0]        rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              mem_write_ctrl,
    output logic              mem_read_ctrl,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);

`ifdef DMEM_ARB_RMW_EN
    typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif

    state_t          state;
    logic            ptr;
    logic            lat_id;
    logic            lat_write;
    logic            winner;
    logic            sel_write;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [BE-1:0]   sel_be;
    logic [1:0]      lat_onehot;

    // Pointer only breaks ties; a lone requester always wins.
    always_comb begin
        winner = (rq_valid == 2'b11) ? ptr : rq_valid[1];
        rq_ready = 2'b00;
        if (state == IDLE && reset_n && (|rq_valid))
            rq_ready = winner ? 2'b10 : 2'b01;
    end

    assign sel_write  = winner ? rq_write[1] : rq_write[0];
    assign sel_addr   = winner ? rq_addr[2*AW-1:AW] : rq_addr[AW-1:0];
    assign sel_wdata  = winner ? rq_wdata[2*DW-1:DW] : rq_wdata[DW-1:0];
    assign sel_be     = winner ? rq_be[2*BE-1:BE] : rq_be[BE-1:0];
    assign lat_onehot = lat_id ? 2'b10 : 2'b01;

`ifdef DMEM_ARB_RMW_EN
    logic [BE-1:0] lat_be;
    logic [DW-1:0] merged;
    logic          lat_partial;

    always_comb begin
        merged = mem_rdata;
        for (int i = 0; i < BE; i++)
            if (lat_be[i]) merged[8*i +: 8] = mem_wdata[8*i +: 8];
    end

    assign lat_partial = (lat_be != '1) && (lat_be != '0);
`else
    logic unused_be;
    assign unused_be = ^{sel_be, rq_be};
`endif

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            ptr            <= 1'b0;
            lat_id         <= 1'b0;
            lat_write      <= 1'b0;
            rsp_valid      <= 2'b00;
            rsp_rdata      <= '0;
            mem_write_ctrl <= 1'b0;
            mem_read_ctrl  <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
`ifdef DMEM_ARB_RMW_EN
            lat_be         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|rq_valid) begin
                        state     <= ACCESS;
                        ptr       <= ~winner;
                        lat_id    <= winner;
                        lat_write <= sel_write;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
`ifdef DMEM_ARB_RMW_EN
                        lat_be         <= sel_be;
                        // A store with no enabled lanes touches nothing.
                        mem_read_ctrl  <= !sel_write || ((sel_be != '1) && (sel_be != '0));
                        mem_write_ctrl <= sel_write && (sel_be == '1);
`else
                        mem_read_ctrl  <= !sel_write;
                        mem_write_ctrl <= sel_write;
`endif
                    end
                end
                ACCESS: begin
                    mem_read_ctrl  <= 1'b0;
                    mem_write_ctrl <= 1'b0;
`ifdef DMEM_ARB_RMW_EN
                    if (lat_write && lat_partial) begin
                        mem_wdata      <= merged;
                        mem_write_ctrl <= 1'b1;
                        state          <= RMW_WR;
                    end else
`endif
                    begin
                        rsp_valid <= lat_onehot;
                        rsp_rdata <= lat_write ? '0 : mem_rdata;
                        state     <= RESP;
                    end
                end
`ifdef DMEM_ARB_RMW_EN
                RMW_WR: begin
                    mem_write_ctrl <= 1'b0;
                    rsp_valid      <= lat_onehot;
                    rsp_rdata      <= '0;
                    state          <= RESP;
                end
`endif
                RESP: begin
                    rsp_valid <= 2'b00;
                    rsp_rdata <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
